npc_ifu: RTL and testbench
==========================

Name: npc_ifu

Overview:
- Instruction fetch unit of the NPC core.
- Holds the PC and issues one word-aligned fetch at a time to instruction memory over a valid/ready request and valid response interface.
- Buffers the returned instruction and hands it downstream to the IDU, whose key-indexed opcode lookup muxes consume `inst`, over a valid/ready handshake.
- Accepts branch/jump redirects from EXU at any time and kills any in-flight fetch.

Parameters:
- XLEN, 32, width of PC and addresses.
- ILEN, 32, instruction width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  EXU redirect request; single-cycle pulse.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are dropped.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address; bits [1:0] always 0.
- imem_rsp_valid  in  1  response valid; asserted exactly once per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  ILEN  fetched word.
- inst_valid  out  1  instruction valid to IDU.
- inst_ready  in  1  IDU accepts instruction.
- inst  out  ILEN  buffered instruction.
- inst_pc  out  XLEN  PC of `inst`.

Behaviour:
- One clock `clk`; reset `rst_n` is synchronous, active-low. All registers update only on rising edge of `clk`.
- Registers and reset values:
  - pc = RESET_PC
  - state = S_IDLE
  - kill = 0
  - inst_q = 0
  - inst_pc_q = 0
- Outputs are decoded from state, so all outputs are 0 during reset and in S_IDLE.
- States:
  - S_IDLE: no outputs. Next state is always S_REQ. redirect_valid here sets pc = redirect_pc.
  - S_REQ:
    - imem_req_valid = 1, imem_req_addr = pc.
    - Request fires when imem_req_ready = 1. Then go to S_WAIT, with kill = redirect_valid.
    - If redirect_valid is set in the same cycle the request fires, pc still loads redirect_pc.
    - Redirect without firing: pc = redirect_pc, stay in S_REQ. The address changes while valid is held high; imem must tolerate this.
  - S_WAIT:
    - No request is issued.
    - redirect_valid sets kill = 1 and pc = redirect_pc.
    - When imem_rsp_valid = 1:
      - If kill = 1 or redirect_valid = 1: discard the data, clear kill, go to S_REQ.
      - Otherwise: inst_q = imem_rsp_data, inst_pc_q = pc, pc = pc + 4 (wraps modulo 2^XLEN), go to S_HOLD.
  - S_HOLD:
    - inst_valid = !redirect_valid; inst = inst_q; inst_pc = inst_pc_q.
    - inst_ready = 1 with no redirect: handshake completes, go to S_REQ.
    - redirect_valid: drop the buffered instruction, pc = redirect_pc, go to S_REQ.
    - Redirect has priority over a simultaneous inst_ready; that handshake does not count.
- Latency and throughput:
  - Minimum fetch-to-issue is request cycle + 1 wait cycle, then inst_valid the following cycle.
  - At most one outstanding request. Throughput is one instruction per 3 cycles at best.
- inst and inst_pc are stable while inst_valid = 1 and inst_ready = 0.
- Reset mid-operation (rst_n = 0 in any state) returns to S_IDLE with pc = RESET_PC next cycle.
  - A response arriving in S_IDLE or S_REQ is ignored.
  - The memory side is reset by the same rst_n.
- No misalignment exception is raised; low address bits are silently zeroed.

Decomposition:
- Shared package npc_pkg holds:
  - XLEN, ILEN, RESET_PC
  - ifu_state_t enum {S_IDLE, S_REQ, S_WAIT, S_HOLD} (2-bit encoding)
  - INST_NOP = 32'h0000_0013
- No sub-module: the PC, state, kill flag and one-entry buffer are all inline.

Test Plan:
- Reset release with imem_req_ready = 1 and 1-cycle response latency: first imem_req_addr = 32'h8000_0000. inst = response word, inst_pc = 32'h8000_0000. Next request address = 32'h8000_0004.
- IDU backpressure: inst_ready = 0 for 5 cycles, with rsp = 32'h00100093. inst_valid stays 1, inst/inst_pc stay constant, no new imem request. After inst_ready = 1, the next request is issued the following cycle.
- Redirect in S_WAIT to 32'h8000_0100: the stale response is discarded, inst_valid never rises for it, and the next imem_req_addr = 32'h8000_0100.
- Redirect with the request firing in the same cycle: the response is killed, and the following request address is the redirect target. Redirect_pc = 32'h8000_0203 gives 32'h8000_0200.
- Redirect in S_HOLD together with inst_ready = 1: inst_valid = 0 that cycle, no IDU handshake, next request = redirect target.
- rst_n = 0 asserted in S_WAIT: next cycle all outputs are 0; after release, the first request is to 32'h8000_0000 and any late response is ignored.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC front end.
//   XLEN / ILEN : address and instruction widths
//   RESET_PC    : first fetch address after reset
//   INST_NOP    : canonical NOP encoding (addi x0, x0, 0)
//   ifu_state_t : fetch unit state encoding
//   align_pc()  : clears the low two bits of a fetch address
package npc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_t;

  // Fetches are always word aligned; misaligned targets are silently truncated.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_MASK;
  endfunction

endpackage

// File: rtl/npc_ifu_if.sv
// npc_ifu_if: instruction memory bus between the fetch unit and imem.
//   req_valid / req_ready / req_addr : fetch request channel (valid/ready)
//   rsp_valid / rsp_data             : response channel (valid only, one per accepted request)
//   master modport : fetch unit side
//   slave  modport : memory side
interface npc_ifu_if;
  import npc_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [ILEN-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/npc_ifu.sv
// npc_ifu: instruction fetch unit. Holds the PC, issues one fetch at a time to
// imem, buffers the returned word and offers it to the IDU.
//   clk, rst_n         : clock, synchronous active-low reset
//   redirect_valid/pc  : EXU branch/jump redirect (single-cycle pulse)
//   imem               : instruction memory bus (master side)
//   inst_valid/ready   : handshake to the IDU
//   inst, inst_pc      : buffered instruction and its PC
//
// state  | meaning
// S_IDLE | just out of reset, nothing issued
// S_REQ  | request presented to imem at pc
// S_WAIT | request accepted, waiting for the response (kill marks it stale)
// S_HOLD | instruction buffered, offered to the IDU
module npc_ifu
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  npc_ifu_if.master       imem,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  ifu_state_t      state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic [ILEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) pc <= align_pc(redirect_pc);
          state <= S_REQ;
        end

        S_REQ: begin
          // pc follows a redirect even while the request is held; if the
          // request fires in the same cycle, the in-flight fetch is stale.
          if (redirect_valid) pc <= align_pc(redirect_pc);
          if (imem.req_ready) begin
            state <= S_WAIT;
            kill  <= redirect_valid;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            kill <= 1'b1;
            pc   <= align_pc(redirect_pc);
          end
          if (imem.rsp_valid) begin
            if (kill || redirect_valid) begin
              // Later assignment wins: a redirect landing with the response
              // still leaves kill clear for the next fetch.
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              inst_q    <= imem.rsp_data;
              inst_pc_q <= pc;
              pc        <= pc + XLEN'(4);
              state     <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // Redirect wins over a simultaneous IDU accept; the buffered word is dropped.
          if (redirect_valid) begin
            pc    <= align_pc(redirect_pc);
            state <= S_REQ;
          end else if (inst_ready) begin
            state <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem.req_valid = (state == S_REQ);
    imem.req_addr  = (state == S_REQ) ? pc : '0;
    inst_valid     = (state == S_HOLD) && !redirect_valid;
    inst           = (state == S_HOLD) ? inst_q : '0;
    inst_pc        = (state == S_HOLD) ? inst_pc_q : '0;
  end

endmodule

// File: tb/tb_npc_ifu.sv
// tb_npc_ifu: scoreboard bench for the fetch unit. Expected request addresses
// and expected instructions are queued as stimulus is driven and popped when
// the DUT presents them.
module tb_npc_ifu;
  import npc_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            inst_ready = 1'b0;
  logic            inst_valid;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  npc_ifu_if imem();

  npc_ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (imem),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]      exp_req[$];
  logic [ILEN+XLEN-1:0] exp_inst[$];

  // Advance until a request is presented (sampled 1ns after the falling edge).
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (imem.req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // From S_REQ with req_ready high: accept, answer after one wait cycle, land in S_HOLD.
  task automatic respond(input logic [ILEN-1:0] d, input logic [XLEN-1:0] a);
    @(negedge clk);
    imem.rsp_valid = 1'b1;
    imem.rsp_data  = d;
    exp_inst.push_back({d, a});
    @(negedge clk);
    imem.rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem.req_ready = 1'b1;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (imem.req_valid !== 1'b0 || imem.req_addr !== '0) begin
      errors++;
      $display("FAIL reset_req got valid=%b addr=%h exp valid=0 addr=0", imem.req_valid, imem.req_addr);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst !== '0 || inst_pc !== '0) begin
      errors++;
      $display("FAIL reset_inst got valid=%b inst=%h pc=%h exp all 0", inst_valid, inst, inst_pc);
    end
    exp_req.push_back(RESET_PC);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    logic [XLEN-1:0] ea;
    logic [ILEN+XLEN-1:0] ei;
    wait_req(ok);
    ea = exp_req.pop_front();
    checks++;
    if (!ok || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL basic_req_addr got ok=%b addr=%h exp %h", ok, imem.req_addr, ea);
    end
    respond(32'h0000_0513, ea);
    #1;
    ei = exp_inst.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== ei[ILEN+XLEN-1:XLEN] || inst_pc !== ei[XLEN-1:0]) begin
      errors++;
      $display("FAIL basic_inst got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h",
               inst_valid, inst, inst_pc, ei[ILEN+XLEN-1:XLEN], ei[XLEN-1:0]);
    end
    inst_ready = 1'b1;
    exp_req.push_back(ea + 32'd4);
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [XLEN-1:0] ea;
    logic [ILEN+XLEN-1:0] ei;
    wait_req(ok);
    ea = exp_req.pop_front();
    checks++;
    if (!ok || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL bp_req_addr got ok=%b addr=%h exp %h", ok, imem.req_addr, ea);
    end
    respond(32'h0010_0093, ea);
    ei = exp_inst.pop_front();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== ei[ILEN+XLEN-1:XLEN] || inst_pc !== ei[XLEN-1:0] ||
          imem.req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%b inst=%h pc=%h req=%b exp v=1 inst=%h pc=%h req=0",
                 i, inst_valid, inst, inst_pc, imem.req_valid, ei[ILEN+XLEN-1:XLEN], ei[XLEN-1:0]);
      end
      @(negedge clk);
    end
    inst_ready = 1'b1;
    exp_req.push_back(ea + 32'd4);
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    checks++;
    if (imem.req_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_req got req_valid=%b exp 1", imem.req_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    logic [XLEN-1:0] ea;
    wait_req(ok);
    ea = exp_req.pop_front();
    checks++;
    if (!ok || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL rw_req_addr got ok=%b addr=%h exp %h", ok, imem.req_addr, ea);
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    #1;
    checks++;
    if (imem.req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_wait got req=%b v=%b exp 0 0", imem.req_valid, inst_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    imem.rsp_valid = 1'b1;
    imem.rsp_data  = 32'hdead_beef;
    exp_req.push_back(32'h8000_0100);
    @(negedge clk);
    imem.rsp_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem.req_valid !== 1'b1 || imem.req_addr !== exp_req[0]) begin
      errors++;
      $display("FAIL rw_discard got v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
               inst_valid, imem.req_valid, imem.req_addr, exp_req[0]);
    end
  endtask

  task automatic test_redirect_fire();
    bit ok;
    logic [XLEN-1:0] ea;
    logic [ILEN+XLEN-1:0] ei;
    wait_req(ok);
    ea = exp_req.pop_front();
    checks++;
    if (!ok || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL rf_req_addr got ok=%b addr=%h exp %h", ok, imem.req_addr, ea);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem.rsp_valid = 1'b1;
    imem.rsp_data  = 32'hbad0_0bad;
    exp_req.push_back(32'h8000_0200);
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rf_killed got v=%b exp 0", inst_valid);
    end
    @(negedge clk);
    imem.rsp_valid = 1'b0;
    #1;
    ea = exp_req.pop_front();
    checks++;
    if (inst_valid !== 1'b0 || imem.req_valid !== 1'b1 || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL rf_target got v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
               inst_valid, imem.req_valid, imem.req_addr, ea);
    end
    respond(32'h0020_0113, ea);
    #1;
    ei = exp_inst.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== ei[ILEN+XLEN-1:XLEN] || inst_pc !== ei[XLEN-1:0]) begin
      errors++;
      $display("FAIL rf_inst got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h",
               inst_valid, inst, inst_pc, ei[ILEN+XLEN-1:XLEN], ei[XLEN-1:0]);
    end
  endtask

  // Starts in S_HOLD (left there by test_redirect_fire).
  task automatic test_redirect_hold();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_valid got v=%b exp 0", inst_valid);
    end
    exp_req.push_back(32'h8000_0400);
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== exp_req[0] || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_target got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
               imem.req_valid, imem.req_addr, inst_valid, exp_req[0]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [XLEN-1:0] ea;
    logic [ILEN+XLEN-1:0] ei;
    wait_req(ok);
    ea = exp_req.pop_front();
    checks++;
    if (!ok || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL wr_req_addr got ok=%b addr=%h exp %h", ok, imem.req_addr, ea);
    end
    imem.req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_ffff;
    exp_req.push_back(32'hffff_fffc);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    #1;
    ea = exp_req.pop_front();
    checks++;
    if (imem.req_valid !== 1'b1 || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL wr_held_req got req=%b addr=%h exp req=1 addr=%h", imem.req_valid, imem.req_addr, ea);
    end
    imem.req_ready = 1'b1;
    respond(32'h0030_0193, ea);
    #1;
    ei = exp_inst.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== ei[ILEN+XLEN-1:XLEN] || inst_pc !== ei[XLEN-1:0]) begin
      errors++;
      $display("FAIL wr_inst got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h",
               inst_valid, inst, inst_pc, ei[ILEN+XLEN-1:XLEN], ei[XLEN-1:0]);
    end
    inst_ready = 1'b1;
    exp_req.push_back(ea + 32'd4);
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [XLEN-1:0] ea;
    logic [ILEN+XLEN-1:0] ei;
    wait_req(ok);
    ea = exp_req.pop_front();
    checks++;
    if (!ok || imem.req_addr !== ea) begin
      errors++;
      $display("FAIL rm_req_addr got ok=%b addr=%h exp %h", ok, imem.req_addr, ea);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    imem.rsp_valid = 1'b1;
    imem.rsp_data  = 32'hffff_ffff;
    #1;
    checks++;
    if (imem.req_valid !== 1'b0 || imem.req_addr !== '0 || inst_valid !== 1'b0 ||
        inst !== '0 || inst_pc !== '0) begin
      errors++;
      $display("FAIL rm_outputs got req=%b addr=%h v=%b inst=%h pc=%h exp all 0",
               imem.req_valid, imem.req_addr, inst_valid, inst, inst_pc);
    end
    rst_n = 1'b1;
    imem.req_ready = 1'b0;
    exp_req.push_back(RESET_PC);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (imem.req_valid !== 1'b1 || imem.req_addr !== exp_req[0] || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL rm_restart%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                 i, imem.req_valid, imem.req_addr, inst_valid, exp_req[0]);
      end
    end
    imem.rsp_valid = 1'b0;
    imem.req_ready = 1'b1;
    ea = exp_req.pop_front();
    respond(32'h1234_5678, ea);
    #1;
    ei = exp_inst.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || inst !== ei[ILEN+XLEN-1:XLEN] || inst_pc !== ei[XLEN-1:0]) begin
      errors++;
      $display("FAIL rm_inst got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h",
               inst_valid, inst, inst_pc, ei[ILEN+XLEN-1:XLEN], ei[XLEN-1:0]);
    end
    inst_ready = 1'b1;
    exp_req.push_back(ea + 32'd4);
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [XLEN-1:0] ea;
    logic [ILEN+XLEN-1:0] ei;
    logic [ILEN-1:0] d;
    int lat;
    int bp;
    for (int n = 0; n < 6; n++) begin
      wait_req(ok);
      ea = exp_req.pop_front();
      checks++;
      if (!ok || imem.req_addr !== ea) begin
        errors++;
        $display("FAIL b2b_req%0d got ok=%b addr=%h exp %h", n, ok, imem.req_addr, ea);
      end
      lat = int'($urandom_range(1, 3));
      bp  = int'($urandom_range(0, 2));
      d   = $urandom;
      @(negedge clk);
      repeat (lat - 1) @(negedge clk);
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = d;
      exp_inst.push_back({d, ea});
      @(negedge clk);
      imem.rsp_valid = 1'b0;
      repeat (bp) @(negedge clk);
      #1;
      ei = exp_inst.pop_front();
      checks++;
      if (inst_valid !== 1'b1 || inst !== ei[ILEN+XLEN-1:XLEN] || inst_pc !== ei[XLEN-1:0]) begin
        errors++;
        $display("FAIL b2b_inst%0d got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h",
                 n, inst_valid, inst, inst_pc, ei[ILEN+XLEN-1:XLEN], ei[XLEN-1:0]);
      end
      inst_ready = 1'b1;
      exp_req.push_back(ea + 32'd4);
      @(negedge clk);
      inst_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_fire();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
